// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
//   MULT/MULTU/DIV/DIVU latch their operands at launch and hold Busy for a fixed
//   number of cycles. The result is committed to HI/LO on the final busy edge.
//   MTHI/MTLO write HI/LO directly from A with a latency of one cycle.
//
// Ports
//   Clk    in   clock, rising-edge
//   Reset  in   synchronous, active-high; clears HI/LO and aborts any operation
//   Start  in   launch the operation selected by Op (sampled only while idle)
//   Op     in   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   A, B   in   operands rs / rt
//   Busy   out  high while a multiply/divide is in flight
//   HI, LO out  architectural HI/LO registers
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic [31:0]        hi_q, lo_q;
    op_e                op_q;
    logic [31:0]        a_q, b_q;

    // Result of the latched operation, evaluated from the latched operands.
    logic [63:0]        prod_s, prod_u;
    logic [31:0]        a_mag, b_mag, b_safe, b_mag_safe;
    logic [31:0]        quot_u, rem_u, quot_m, rem_m;
    logic [31:0]        res_hi, res_lo;
    logic               res_commit;

    always_comb begin
        prod_s     = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u     = {32'b0, a_q} * {32'b0, b_q};

        // Divider inputs forced non-zero so the arithmetic is always defined;
        // the zero-divisor case suppresses the commit instead.
        b_safe     = (b_q == '0) ? 32'd1 : b_q;
        a_mag      = a_q[31] ? (~a_q + 32'd1) : a_q;
        b_mag      = b_q[31] ? (~b_q + 32'd1) : b_q;
        b_mag_safe = (b_mag == '0) ? 32'd1 : b_mag;
        quot_u     = a_q / b_safe;
        rem_u      = a_q % b_safe;
        // Signed divide via magnitudes: 0x80000000 / -1 falls out as 0x80000000 rem 0.
        quot_m     = a_mag / b_mag_safe;
        rem_m      = a_mag % b_mag_safe;

        res_hi     = hi_q;
        res_lo     = lo_q;
        res_commit = 1'b0;
        case (op_q)
            OP_MULT: begin
                {res_hi, res_lo} = prod_s;
                res_commit       = 1'b1;
            end
            OP_MULTU: begin
                {res_hi, res_lo} = prod_u;
                res_commit       = 1'b1;
            end
            OP_DIV: begin
                res_lo     = (a_q[31] ^ b_q[31]) ? (~quot_m + 32'd1) : quot_m;
                res_hi     = a_q[31] ? (~rem_m + 32'd1) : rem_m;
                res_commit = (b_q != '0);
            end
            OP_DIVU: begin
                res_lo     = quot_u;
                res_hi     = rem_u;
                res_commit = (b_q != '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            op_q    <= OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        case (op_e'(Op))
                            OP_MULT, OP_MULTU: begin
                                op_q    <= op_e'(Op);
                                a_q     <= A;
                                b_q     <= B;
                                cnt_q   <= CNT_W'(MULT_CYCLES);
                                busy_q  <= 1'b1;
                                state_q <= S_RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                op_q    <= op_e'(Op);
                                a_q     <= A;
                                b_q     <= B;
                                cnt_q   <= CNT_W'(DIV_CYCLES);
                                busy_q  <= 1'b1;
                                state_q <= S_RUN;
                            end
                            OP_MTHI: hi_q <= A;
                            OP_MTLO: lo_q <= A;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (cnt_q == CNT_W'(1)) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                        if (res_commit) begin
                            hi_q <= res_hi;
                            lo_q <= res_lo;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Directed scenarios followed by randomized traffic. A transaction-level
//   model (remaining busy cycles + pending result computed with plain integer
//   arithmetic) predicts Busy/HI/LO after every clock edge.
module tb_mult_div_unit;

    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [2:0]  Op = '0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        Busy;
    logic [31:0] HI, LO;

    mult_div_unit #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .Start(Start),
        .Op   (Op),
        .A    (A),
        .B    (B),
        .Busy (Busy),
        .HI   (HI),
        .LO   (LO)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [31:0] m_rhi = '0, m_rlo = '0;
    logic        m_commit = 1'b0;
    int          m_left = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic st, input logic [2:0] op,
                              input logic [31:0] a, input logic [31:0] b);
        longint          ps;
        longint unsigned pu;
        int              sn, sd;
        if (rst) begin
            m_hi   = '0;
            m_lo   = '0;
            m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_commit) begin
                m_hi = m_rhi;
                m_lo = m_rlo;
            end
        end else if (st) begin
            case (op)
                3'd0: begin
                    ps = longint'($signed(a)) * longint'($signed(b));
                    {m_rhi, m_rlo} = ps;
                    m_commit = 1'b1;
                    m_left   = MULT_N;
                end
                3'd1: begin
                    pu = longint'({32'b0, a}) * longint'({32'b0, b});
                    {m_rhi, m_rlo} = pu;
                    m_commit = 1'b1;
                    m_left   = MULT_N;
                end
                3'd2: begin
                    m_commit = (b != 0);
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        m_rlo = 32'h8000_0000;
                        m_rhi = 32'h0;
                    end else if (b != 0) begin
                        sn = $signed(a);
                        sd = $signed(b);
                        m_rlo = sn / sd;
                        m_rhi = sn % sd;
                    end
                    m_left = DIV_N;
                end
                3'd3: begin
                    m_commit = (b != 0);
                    if (b != 0) begin
                        m_rlo = a / b;
                        m_rhi = a % b;
                    end
                    m_left = DIV_N;
                end
                3'd4: m_hi = a;
                3'd5: m_lo = a;
                default: ;
            endcase
        end
    endtask

    task automatic step(input logic rst, input logic st, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
        @(negedge Clk);
        Reset = rst;
        Start = st;
        Op    = op;
        A     = a;
        B     = b;
        @(posedge Clk);
        model_edge(rst, st, op, a, b);
        #1;
        check_eq("busy", {31'b0, Busy}, {31'b0, (m_left > 0)});
        check_eq("hi", HI, m_hi);
        check_eq("lo", LO, m_lo);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, $urandom, $urandom);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        // Reset then idle
        step(1'b1, 1'b0, 3'd0, '0, '0);
        step(1'b1, 1'b0, 3'd0, '0, '0);
        check_eq("rst_hi", HI, 32'h0);
        check_eq("rst_lo", LO, 32'h0);
        check_eq("rst_busy", {31'b0, Busy}, 32'h0);
        idle(3);

        // MULT -2 * 3
        step(1'b0, 1'b1, 3'd0, 32'hFFFF_FFFE, 32'd3);
        idle(MULT_N);
        check_eq("mult_hi", HI, 32'hFFFF_FFFF);
        check_eq("mult_lo", LO, 32'hFFFF_FFFA);

        // MULTU max * max
        step(1'b0, 1'b1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle(MULT_N);
        check_eq("multu_hi", HI, 32'hFFFF_FFFE);
        check_eq("multu_lo", LO, 32'h0000_0001);

        // DIV -7 / 2
        step(1'b0, 1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2);
        idle(DIV_N);
        check_eq("div_hi", HI, 32'hFFFF_FFFF);
        check_eq("div_lo", LO, 32'hFFFF_FFFD);

        // DIVU by zero keeps previous HI/LO
        step(1'b0, 1'b1, 3'd4, 32'h11, '0);
        step(1'b0, 1'b1, 3'd5, 32'h22, '0);
        step(1'b0, 1'b1, 3'd3, 32'd7, 32'd0);
        idle(DIV_N);
        check_eq("div0_hi", HI, 32'h11);
        check_eq("div0_lo", LO, 32'h22);

        // MTHI, then DIVU with MTLO and operand changes during busy
        step(1'b0, 1'b1, 3'd4, 32'h1234, '0);
        check_eq("mthi_hi", HI, 32'h1234);
        check_eq("mthi_busy", {31'b0, Busy}, 32'h0);
        step(1'b0, 1'b1, 3'd3, 32'd100, 32'd7);
        for (int i = 0; i < int'(DIV_N); i++) step(1'b0, 1'b1, 3'd5, $urandom, $urandom);
        check_eq("divu_hi", HI, 32'd2);
        check_eq("divu_lo", LO, 32'd14);
        idle(1);

        // Same launch, reset mid-run
        step(1'b0, 1'b1, 3'd3, 32'd100, 32'd7);
        idle(3);
        step(1'b1, 1'b0, 3'd0, '0, '0);
        check_eq("abort_hi", HI, 32'h0);
        check_eq("abort_lo", LO, 32'h0);
        check_eq("abort_busy", {31'b0, Busy}, 32'h0);
        idle(DIV_N);

        // Signed overflow divide
        step(1'b0, 1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(DIV_N);
        check_eq("ovf_hi", HI, 32'h0);
        check_eq("ovf_lo", LO, 32'h8000_0000);

        // Start held high: relaunches only after Busy falls
        for (int i = 0; i < 3 * int'(MULT_N); i++) step(1'b0, 1'b1, 3'd1, 32'd6 + 32'(i), 32'd7);
        idle(MULT_N);

        // Reset beats Start on the same edge
        step(1'b1, 1'b1, 3'd4, 32'hDEAD_BEEF, '0);
        check_eq("rst_prio_hi", HI, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0,
                 3'($urandom_range(0, 7)), pick_operand(), pick_operand());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers, sitting beside the register file in the execute stage. It consumes the two register-file read ports as operands (A from RD1, B from RD2). It produces HI/LO values that the mfhi/mflo datapath routes back into the register-file write-data mux. Busy is exported to the controller, which must hold further MDU-class instructions while it is high.

## Interface
- MULT_CYCLES, 5, cycles Busy stays high for MULT/MULTU (>=1)
- DIV_CYCLES, 10, cycles Busy stays high for DIV/DIVU (>=1)

- Clk  input  1  clock, all state updates on rising edge
- Reset  input  1  reset, synchronous, active-high
- Start  input  1  launch the operation selected by Op; sampled on the rising edge
- Op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved (no-op)
- A  input  32  operand rs (dividend / multiplicand / mthi-mtlo source)
- B  input  32  operand rt (divisor / multiplier)
- Busy  output  1  high while a MULT/DIV operation is in flight
- HI  output  32  architectural HI register
- LO  output  32  architectural LO register

## Operation
- States: IDLE, RUN. Down-counter CNT sized for max(MULT_CYCLES, DIV_CYCLES).
- IDLE, Start=1, Op in {0..3}: latch A, B, Op into internal regs; CNT <= MULT_CYCLES or DIV_CYCLES; go RUN.
- IDLE, Start=1, Op=4: HI <= A. Op=5: LO <= A. Both stay in IDLE, Busy never rises.
- IDLE, Start=1, Op in {6,7}: no state change.
- RUN: CNT decrements each edge. On the edge where CNT reaches 1, commit the result to HI/LO and return to IDLE.
- HI/LO keep their old values for the whole RUN; no partial results are visible.
- Start in RUN: ignored, including MTHI/MTLO. Latched operands are unaffected by A/B changes after launch.
- MULT: {HI,LO} = signed(A) * signed(B), 64-bit. MULTU: unsigned 64-bit product.
- DIV: LO = signed quotient truncated toward zero. HI = remainder, with the sign of the dividend.
- DIVU: LO = A / B, HI = A % B, unsigned.
- Divide by zero (latched B = 0, DIV or DIVU): full DIV_CYCLES busy period runs, then HI and LO retain their previous values.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0x00000000, with no trap.
- The result may be computed combinationally at launch and held in a shadow register. The counter is what defines visibility.

## Timing
- Reset (any state, including mid-RUN): HI = 0, LO = 0, Busy = 0, state IDLE, CNT = 0. An in-flight operation is discarded.
- Reset has priority over Start on the same edge.
- Launch edge E0 (Start=1, IDLE, Op 0..3): Busy = 1 from after E0.
- Busy stays high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
- At edge E_N, HI/LO update and Busy falls together. The new HI/LO are readable in the cycle after E_N.
- Back-to-back: Start asserted in the cycle Busy has just fallen is accepted. A Start held high while Busy=1 is accepted only once Busy=0, at the first edge sampled in IDLE.
- MTHI/MTLO: the value is visible the cycle after the sampling edge. Latency is 1, with no busy period.
- Busy and HI/LO are pure register outputs with no combinational path from the inputs.

## Test plan
- Reset then idle: Reset=1 for 2 cycles → HI=0, LO=0, Busy=0. Start held low → values unchanged.
- MULT signed: A=0xFFFFFFFE (-2), B=3, Start for 1 cycle.
  - Busy is high exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU: A=B=0xFFFFFFFF → after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- DIV: A=-7 (0xFFFFFFF9), B=2 → after 10 busy cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU: A=7, B=0, with HI/LO previously 0x11/0x22 → Busy for 10 cycles, then HI=0x11, LO=0x22 unchanged.
- Interference: MTHI A=0x1234 in IDLE → HI=0x1234 next cycle with no Busy.
  - Then launch DIVU 100/7. Assert MTLO and change A/B during Busy → both ignored.
  - Result: HI=2, LO=14.
  - Repeat the launch and assert Reset at busy cycle 4 → HI=LO=0 and Busy=0 the next cycle.
